// File: rtl/half_sub_bist.sv
// ============================================================================
// Module      : half_sub_bist
// Description : Built-in self-test engine for a half-subtracter cell.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module half_sub_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             difference,
   input  logic             bout,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [3:0]       fail_vector
);

   localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
   logic              a_q, a_d;
   logic              b_q, b_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              fail_valid_q, fail_valid_d;
   logic [3:0]        fail_vector_q, fail_vector_d;

   logic w_exp_diff;
   logic w_exp_bout;
   logic w_mismatch;

   assign w_exp_diff = a_q ^ b_q;
   assign w_exp_bout = ~a_q & b_q;
   assign w_mismatch = (w_exp_diff != difference) || (w_exp_bout != bout);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pass_idx_d    = pass_idx_q;
      a_d           = a_q;
      b_d           = b_q;
      busy_d        = busy_q;
      done_d        = done_q;
      err_count_d   = err_count_q;
      fail_valid_d  = fail_valid_q;
      fail_vector_d = fail_vector_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d           = 1'b0;
               b_d           = 1'b0;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               err_count_d   = '0;
               fail_valid_d  = 1'b0;
               fail_vector_d = '0;
               cnt_d         = '0;
               pass_idx_d    = '0;
               state_d       = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_mismatch) begin
               if (err_count_q != ERR_MAX) begin
                  err_count_d = err_count_q + 1'b1;
               end
               if (!fail_valid_q) begin
                  fail_vector_d = {a_q, b_q, difference, bout};
                  fail_valid_d  = 1'b1;
               end
            end
            cnt_d = '0;
            if (!(a_q && b_q)) begin
               {a_d, b_d} = {a_q, b_q} + 2'd1;
               state_d    = S_SETTLE;
            end else if (pass_idx_q < PASS_LAST) begin
               a_d        = 1'b0;
               b_d        = 1'b0;
               pass_idx_d = pass_idx_q + 1'b1;
               state_d    = S_SETTLE;
            end else begin
               a_d     = 1'b0;
               b_d     = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pass_idx_q    <= '0;
         a_q           <= 1'b0;
         b_q           <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_count_q   <= '0;
         fail_valid_q  <= 1'b0;
         fail_vector_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pass_idx_q    <= pass_idx_d;
         a_q           <= a_d;
         b_q           <= b_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_count_q   <= err_count_d;
         fail_valid_q  <= fail_valid_d;
         fail_vector_q <= fail_vector_d;
      end
   end

   assign a           = a_q;
   assign b           = b_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = done_q && (err_count_q == '0);
   assign err_count   = err_count_q;
   assign fail_valid  = fail_valid_q;
   assign fail_vector = fail_vector_q;

endmodule

`default_nettype wire

// File: tb/tb_half_sub_bist.sv
// ============================================================================
// Module      : tb_half_sub_bist
// Description : Directed-vector bench for half_sub_bist with a faultable cell.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_half_sub_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_p5 = 1'b0;
   logic [1:0] fault = 2'd0;

   logic       difference, bout, a, b, busy, done, pass, fail_valid;
   logic [3:0] err_count, fail_vector;

   logic       difference_p5, bout_p5, a_p5, b_p5, busy_p5, done_p5, pass_p5, fail_valid_p5;
   logic [3:0] err_count_p5, fail_vector_p5;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Cell model: fault 1 = bout stuck-at-0, fault 2 = difference inverted.
   assign difference = (fault == 2'd2) ? ~(a ^ b) : (a ^ b);
   assign bout       = (fault == 2'd1) ? 1'b0 : (~a & b);

   assign difference_p5 = ~(a_p5 ^ b_p5);
   assign bout_p5       = ~a_p5 & b_p5;

   half_sub_bist #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .difference(difference), .bout(bout),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_vector(fail_vector)
   );

   half_sub_bist #(.SETTLE_CYCLES(2), .PASSES(5), .ERR_W(4)) u_dut_p5 (
      .clk(clk), .rst(rst), .start(start_p5), .difference(difference_p5), .bout(bout_p5),
      .a(a_p5), .b(b_p5), .busy(busy_p5), .done(done_p5), .pass(pass_p5),
      .err_count(err_count_p5), .fail_valid(fail_valid_p5), .fail_vector(fail_vector_p5)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 200) begin
         tick();
         cycles++;
      end
   endtask

   task automatic check_idle_zero(input string tag);
      n_vec++;
      if ({a, b, busy, done, pass, err_count, fail_valid, fail_vector} !== 15'd0) begin
         n_err++;
         $display("FAIL %s outputs: got %b, want all zero", tag,
                  {a, b, busy, done, pass, err_count, fail_valid, fail_vector});
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      check_idle_zero("reset");
      rst = 1'b0;
      tick();
      check_idle_zero("idle_after_reset");
   endtask

   task automatic test_good_cell;
      int cyc;
      fault = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL good_busy got %b want 1", busy); end
      for (int k = 0; k < 12; k++) begin
         logic [1:0] want;
         want = 2'(k / 3);
         n_vec++;
         if ({a, b} !== want) begin
            n_err++;
            $display("FAIL good_vector cycle %0d got %b want %b", k, {a, b}, want);
         end
         if (k < 11) tick();
      end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL good_done_early got %b want 0", done); end
      tick();
      n_vec++;
      if ({done, pass, busy, err_count, fail_valid, a, b} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00}) begin
         n_err++;
         $display("FAIL good_verdict got done=%b pass=%b busy=%b err=%0d fv=%b ab=%b want 1 1 0 0 0 00",
                  done, pass, busy, err_count, fail_valid, {a, b});
      end
      tick();
      n_vec++;
      if ({done, pass} !== 2'b11) begin n_err++; $display("FAIL good_done_hold got %b want 11", {done, pass}); end
      cyc = 0;
   endtask

   task automatic test_bout_stuck;
      int cyc;
      fault = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      n_vec++;
      if (cyc != 12) begin n_err++; $display("FAIL bout_latency got %0d want 12", cyc); end
      n_vec++;
      if ({pass, err_count, fail_valid, fail_vector} !== {1'b0, 4'd1, 1'b1, 4'b0110}) begin
         n_err++;
         $display("FAIL bout_verdict got pass=%b err=%0d fv=%b vec=%b want 0 1 1 0110",
                  pass, err_count, fail_valid, fail_vector);
      end
   endtask

   task automatic test_diff_inverted;
      int cyc;
      fault = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      n_vec++;
      if ({pass, err_count, fail_valid, fail_vector} !== {1'b0, 4'd4, 1'b1, 4'b0010}) begin
         n_err++;
         $display("FAIL diffinv_verdict got pass=%b err=%0d fv=%b vec=%b want 0 4 1 0010",
                  pass, err_count, fail_valid, fail_vector);
      end
   endtask

   task automatic test_mid_run_reset;
      int cyc;
      fault = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if ({busy, done, err_count, fail_valid, fail_vector} !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0}) begin
         n_err++;
         $display("FAIL restart_clear got busy=%b done=%b err=%0d fv=%b vec=%b want 1 0 0 0 0000",
                  busy, done, err_count, fail_valid, fail_vector);
      end
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_zero("midrun_reset");
      tick();
      tick();
      check_idle_zero("midrun_stays_idle");
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      n_vec++;
      if (cyc != 12 || pass !== 1'b1) begin
         n_err++;
         $display("FAIL rerun_after_reset got cycles=%0d pass=%b want 12 1", cyc, pass);
      end
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      check_idle_zero("rst_beats_start");
   endtask

   task automatic test_back_to_back;
      int cyc;
      fault = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      n_vec++;
      if (cyc != 8 || pass !== 1'b1) begin
         n_err++;
         $display("FAIL busy_start_ignored got remaining=%0d pass=%b want 8 1", cyc, pass);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if ({done, pass, busy, err_count} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
         n_err++;
         $display("FAIL done_restart got done=%b pass=%b busy=%b err=%0d want 0 0 1 0",
                  done, pass, busy, err_count);
      end
      wait_done(cyc);
      n_vec++;
      if (cyc != 12 || pass !== 1'b1) begin
         n_err++;
         $display("FAIL done_restart_run got cycles=%0d pass=%b want 12 1", cyc, pass);
      end
   endtask

   task automatic test_saturation;
      int cyc;
      start_p5 = 1'b1;
      tick();
      start_p5 = 1'b0;
      cyc = 0;
      while (!done_p5 && cyc < 300) begin
         tick();
         cyc++;
      end
      n_vec++;
      if (cyc != 60) begin n_err++; $display("FAIL sat_latency got %0d want 60", cyc); end
      n_vec++;
      if ({pass_p5, busy_p5, err_count_p5, fail_valid_p5, fail_vector_p5} !== {1'b0, 1'b0, 4'd15, 1'b1, 4'b0010}) begin
         n_err++;
         $display("FAIL sat_verdict got pass=%b busy=%b err=%0d fv=%b vec=%b want 0 0 15 1 0010",
                  pass_p5, busy_p5, err_count_p5, fail_valid_p5, fail_vector_p5);
      end
   endtask

   initial begin
      test_reset();
      test_good_cell();
      test_bout_stuck();
      test_diff_inverted();
      test_mid_run_reset();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
